// File: rtl/cmp_unit_pipe.sv
// cmp_unit_pipe: pipelined compare unit for the ALU.
// Compares A/B (signed or unsigned), selects MAX/MIN, tracks a running maximum,
// and presents a registered, flag-qualified result after 1 or 2 cycles.
module cmp_unit_pipe #(
   parameter int OP_WIDTH    = 8,
   parameter int OUT_WIDTH   = 16,
   parameter int PIPE_STAGES = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [OP_WIDTH-1:0]  A,
   input  logic [OP_WIDTH-1:0]  B,
   input  logic [2:0]           ALU_FUN,
   input  logic                 SIGNED,
   input  logic                 CMP_Enable,
   input  logic                 ACC_CLR,
   output logic [OUT_WIDTH-1:0] CMP_OUT,
   output logic                 CMP_Flag,
   output logic                 ACC_VALID
);

   if ((PIPE_STAGES != 1) && (PIPE_STAGES != 2)) begin : g_bad_stages
      $error("cmp_unit_pipe: PIPE_STAGES must be 1 or 2");
   end

   // Stage 1 state and the running-max tracker
   logic [OUT_WIDTH-1:0] s1_res_d, s1_res_q;
   logic                 s1_vld_d, s1_vld_q;
   logic [OP_WIDTH-1:0]  acc_d, acc_q;
   logic                 acc_valid_d, acc_valid_q;

   // Combinational compare results
   logic                 a_gt_b, a_lt_b, a_eq_b, a_gt_acc;
   logic                 runmax_op;
   logic [OP_WIDTH-1:0]  run_val;
   logic [OP_WIDTH-1:0]  sel_val;
   logic [2:0]           flag_code;
   logic                 use_sel;
   logic [OUT_WIDTH+OP_WIDTH-1:0] sel_wide;

   // Compare logic, running-max update and stage-1 result selection
   always_comb begin
      a_eq_b   = (A == B);
      a_gt_b   = SIGNED ? ($signed(A) > $signed(B))     : (A > B);
      a_lt_b   = SIGNED ? ($signed(A) < $signed(B))     : (A < B);
      a_gt_acc = SIGNED ? ($signed(A) > $signed(acc_q)) : (A > acc_q);

      runmax_op = CMP_Enable && (ALU_FUN == 3'b111);

      // A clear in the same cycle as a RUNMAX makes A the first sample
      run_val = (!acc_valid_q || ACC_CLR || a_gt_acc) ? A : acc_q;

      acc_d       = acc_q;
      acc_valid_d = acc_valid_q;
      if (runmax_op) begin
         acc_d       = run_val;
         acc_valid_d = 1'b1;
      end else if (ACC_CLR) begin
         acc_d       = '0;
         acc_valid_d = 1'b0;
      end

      flag_code = 3'd0;
      sel_val   = '0;
      use_sel   = 1'b0;
      case (ALU_FUN)
         3'b001:  flag_code = a_eq_b  ? 3'd1 : 3'd0;
         3'b010:  flag_code = a_gt_b  ? 3'd2 : 3'd0;
         3'b011:  flag_code = a_lt_b  ? 3'd3 : 3'd0;
         3'b100:  flag_code = !a_eq_b ? 3'd4 : 3'd0;
         3'b101: begin
            sel_val = a_gt_b ? A : B;
            use_sel = 1'b1;
         end
         3'b110: begin
            sel_val = a_lt_b ? A : B;
            use_sel = 1'b1;
         end
         3'b111: begin
            sel_val = run_val;
            use_sel = 1'b1;
         end
         default: flag_code = 3'd0;
      endcase

      sel_wide = {{OUT_WIDTH{SIGNED & sel_val[OP_WIDTH-1]}}, sel_val};

      s1_res_d = '0;
      s1_vld_d = 1'b0;
      if (CMP_Enable) begin
         s1_vld_d = 1'b1;
         s1_res_d = use_sel ? sel_wide[OUT_WIDTH-1:0] : OUT_WIDTH'(flag_code);
      end
   end

   // Stage-1 and tracker registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s1_res_q    <= '0;
         s1_vld_q    <= 1'b0;
         acc_q       <= '0;
         acc_valid_q <= 1'b0;
      end else begin
         s1_res_q    <= s1_res_d;
         s1_vld_q    <= s1_vld_d;
         acc_q       <= acc_d;
         acc_valid_q <= acc_valid_d;
      end
   end

   assign ACC_VALID = acc_valid_q;

   if (PIPE_STAGES == 2) begin : g_two_stage
      logic [OUT_WIDTH-1:0] s2_res_d, s2_res_q;
      logic                 s2_vld_d, s2_vld_q;

      // Second stage is a plain copy of stage 1
      always_comb begin
         s2_res_d = s1_res_q;
         s2_vld_d = s1_vld_q;
      end

      // Stage-2 registers
      always_ff @(posedge CLK or negedge RST) begin
         if (!RST) begin
            s2_res_q <= '0;
            s2_vld_q <= 1'b0;
         end else begin
            s2_res_q <= s2_res_d;
            s2_vld_q <= s2_vld_d;
         end
      end

      assign CMP_OUT  = s2_res_q;
      assign CMP_Flag = s2_vld_q;
   end else begin : g_one_stage
      assign CMP_OUT  = s1_res_q;
      assign CMP_Flag = s1_vld_q;
   end

endmodule

// File: tb/tb_cmp_unit_pipe.sv
// tb_cmp_unit_pipe: checks one- and two-stage instances of cmp_unit_pipe
// against an integer-arithmetic reference model, directed and random.
module tb_cmp_unit_pipe;

   localparam int OPW  = 8;
   localparam int OUTW = 16;

   logic            CLK = 1'b0;
   logic            rst_n;
   logic [OPW-1:0]  a, b;
   logic [2:0]      fun;
   logic            sgn, en, clr;

   logic [OUTW-1:0] out1, out2;
   logic            flag1, flag2, accv1, accv2;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [OPW-1:0]  m_acc;
   bit              m_accv;
   logic [OUTW-1:0] m_p1r, m_p2r;
   bit              m_p1v, m_p2v;

   always #5 CLK = ~CLK;

   cmp_unit_pipe #(.OP_WIDTH(OPW), .OUT_WIDTH(OUTW), .PIPE_STAGES(1)) dut1 (
      .CLK(CLK), .RST(rst_n), .A(a), .B(b), .ALU_FUN(fun), .SIGNED(sgn),
      .CMP_Enable(en), .ACC_CLR(clr), .CMP_OUT(out1), .CMP_Flag(flag1),
      .ACC_VALID(accv1)
   );

   cmp_unit_pipe #(.OP_WIDTH(OPW), .OUT_WIDTH(OUTW), .PIPE_STAGES(2)) dut2 (
      .CLK(CLK), .RST(rst_n), .A(a), .B(b), .ALU_FUN(fun), .SIGNED(sgn),
      .CMP_Enable(en), .ACC_CLR(clr), .CMP_OUT(out2), .CMP_Flag(flag2),
      .ACC_VALID(accv2)
   );

   function automatic int val(input logic [OPW-1:0] x, input bit s);
      if (s) return int'($signed(x));
      return int'({24'd0, x});
   endfunction

   task automatic model_reset();
      m_acc  = '0; m_accv = 0;
      m_p1r  = '0; m_p1v  = 0;
      m_p2r  = '0; m_p2v  = 0;
   endtask

   // Advance the model by one rising edge using the currently driven inputs
   task automatic model_edge();
      int av, bv, nv;
      logic [OUTW-1:0] res;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_p2r = m_p1r; m_p2v = m_p1v;
      av = val(a, sgn);
      bv = val(b, sgn);
      res = '0;
      if (en) begin
         case (fun)
            3'd1: res = (a == b) ? 16'd1 : 16'd0;
            3'd2: res = (av > bv) ? 16'd2 : 16'd0;
            3'd3: res = (av < bv) ? 16'd3 : 16'd0;
            3'd4: res = (a != b) ? 16'd4 : 16'd0;
            3'd5: res = OUTW'((av > bv) ? av : bv);
            3'd6: res = OUTW'((av < bv) ? av : bv);
            default: res = '0;
         endcase
      end
      if (en && fun == 3'd7) begin
         if (!m_accv || clr) nv = av;
         else nv = (av > val(m_acc, sgn)) ? av : val(m_acc, sgn);
         m_acc  = OPW'(nv);
         m_accv = 1;
         res    = OUTW'(nv);
      end else if (clr) begin
         m_acc  = '0;
         m_accv = 0;
      end
      m_p1r = res; m_p1v = en;
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic [7:0] da, input logic [7:0] db, input logic [2:0] df,
                        input logic ds, input logic de, input logic dc);
      a = da; b = db; fun = df; sgn = ds; en = de; clr = dc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) tick();
      n_tests++;
      if (out1 !== 16'd0 || flag1 !== 1'b0 || accv1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_s1: out=%h flag=%b accv=%b, required 0000/0/0", out1, flag1, accv1);
      end
      n_tests++;
      if (out2 !== 16'd0 || flag2 !== 1'b0 || accv2 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_s2: out=%h flag=%b accv=%b, required 0000/0/0", out2, flag2, accv2);
      end
      @(negedge CLK);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_compare();
      drive(8'h90, 8'h10, 3'd2, 1'b0, 1'b1, 1'b0);
      tick();
      n_tests++;
      if (out1 !== 16'd2 || flag1 !== 1'b1) begin
         n_fail++;
         $display("FAIL gt_unsigned: out=%h flag=%b, required 0002/1", out1, flag1);
      end
      drive(8'h90, 8'h10, 3'd2, 1'b1, 1'b1, 1'b0);
      tick();
      n_tests++;
      if (out1 !== 16'd0 || flag1 !== 1'b1) begin
         n_fail++;
         $display("FAIL gt_signed: out=%h flag=%b, required 0000/1", out1, flag1);
      end
      drive(8'h90, 8'h10, 3'd6, 1'b1, 1'b1, 1'b0);
      tick();
      n_tests++;
      if (out1 !== 16'hFF90) begin
         n_fail++;
         $display("FAIL min_signed: out=%h, required ff90", out1);
      end
      drive(8'h90, 8'h10, 3'd5, 1'b0, 1'b1, 1'b0);
      tick();
      n_tests++;
      if (out1 !== 16'h0090) begin
         n_fail++;
         $display("FAIL max_unsigned: out=%h, required 0090", out1);
      end
      drive(8'h10, 8'h90, 3'd4, 1'b0, 1'b0, 1'b0);
      tick();
      n_tests++;
      if (out1 !== 16'd0 || flag1 !== 1'b0) begin
         n_fail++;
         $display("FAIL bubble_zero: out=%h flag=%b, required 0000/0", out1, flag1);
      end
   endtask

   task automatic test_runmax();
      logic [7:0]  seq_a [4] = '{8'd5, 8'd3, 8'd9, 8'd7};
      logic [15:0] seq_r [4] = '{16'd5, 16'd5, 16'd9, 16'd9};
      drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(seq_a[i], 8'hAA, 3'd7, 1'b0, 1'b1, 1'b0);
         tick();
         n_tests++;
         if (out1 !== seq_r[i] || flag1 !== 1'b1 || accv1 !== 1'b1) begin
            n_fail++;
            $display("FAIL runmax_%0d: out=%h flag=%b accv=%b, required %h/1/1",
                     i, out1, flag1, accv1, seq_r[i]);
         end
      end
      drive(8'd2, 8'h00, 3'd7, 1'b0, 1'b1, 1'b1);
      tick();
      n_tests++;
      if (out1 !== 16'd2 || accv1 !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_with_runmax: out=%h accv=%b, required 0002/1", out1, accv1);
      end
      drive(8'd2, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
      n_tests++;
      if (accv1 !== 1'b0 || accv2 !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_alone: accv1=%b accv2=%b, required 0/0", accv1, accv2);
      end
      drive(8'hF0, 8'h00, 3'd7, 1'b1, 1'b1, 1'b0);
      tick();
      drive(8'h05, 8'h00, 3'd7, 1'b1, 1'b1, 1'b0);
      tick();
      n_tests++;
      if (out1 !== 16'h0005) begin
         n_fail++;
         $display("FAIL runmax_signed: out=%h, required 0005", out1);
      end
      drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_pipe2();
      bit          en_pat   [6] = '{1, 1, 0, 1, 0, 0};
      bit          flag_pat [6] = '{0, 0, 1, 1, 0, 1};
      logic [15:0] out_pat  [6] = '{16'd0, 16'd0, 16'd1, 16'd3, 16'd0, 16'd4};
      tick();
      for (int c = 0; c < 6; c++) begin
         // cycle-c inputs: EQ on first op, LT on second, NE on third
         drive(8'h11, (c == 0) ? 8'h11 : 8'h22, (c == 0) ? 3'd1 : (c == 1) ? 3'd3 : 3'd4,
               1'b0, en_pat[c], 1'b0);
         if (c > 0) begin
            n_tests++;
            if (flag2 !== flag_pat[c] || out2 !== out_pat[c]) begin
               n_fail++;
               $display("FAIL pipe2_cycle%0d: out=%h flag=%b, required %h/%b",
                        c, out2, flag2, out_pat[c], flag_pat[c]);
            end
         end
         tick();
      end
      drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         a   = 8'($urandom);
         b   = ($urandom_range(0, 4) == 0) ? a : 8'($urandom);
         fun = 3'($urandom);
         sgn = 1'($urandom);
         en  = ($urandom_range(0, 9) < 8);
         clr = ($urandom_range(0, 9) == 0);
         tick();
         n_tests++;
         if (out1 !== m_p1r || flag1 !== m_p1v || accv1 !== m_accv) begin
            n_fail++;
            $display("FAIL rand_s1_%0d: out=%h flag=%b accv=%b, required %h/%b/%b",
                     i, out1, flag1, accv1, m_p1r, m_p1v, m_accv);
         end
         n_tests++;
         if (out2 !== m_p2r || flag2 !== m_p2v || accv2 !== m_accv) begin
            n_fail++;
            $display("FAIL rand_s2_%0d: out=%h flag=%b accv=%b, required %h/%b/%b",
                     i, out2, flag2, accv2, m_p2r, m_p2v, m_accv);
         end
      end
   endtask

   task automatic test_reset_midflight();
      drive(8'h07, 8'h00, 3'd7, 1'b0, 1'b1, 1'b0);
      tick();
      drive(8'h33, 8'h22, 3'd5, 1'b0, 1'b1, 1'b0);
      tick();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (out1 !== 16'd0 || flag1 !== 1'b0 || accv1 !== 1'b0 ||
          out2 !== 16'd0 || flag2 !== 1'b0 || accv2 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_midflight: s1=%h/%b/%b s2=%h/%b/%b, required all 0",
                  out1, flag1, accv1, out2, flag2, accv2);
      end
      drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      tick();
      @(negedge CLK);
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (flag1 !== 1'b0 || flag2 !== 1'b0 || out2 !== 16'd0) begin
         n_fail++;
         $display("FAIL after_reset: flag1=%b flag2=%b out2=%h, required 0/0/0000",
                  flag1, flag2, out2);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_compare();
      test_runmax();
      test_pipe2();
      test_random();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
